alu_result_mux_pipe: RTL and testbench

//  Parametrised NUM_IN-to-1 result selector for the ALU output stage, generalising the fixed 64-bit 8:1 mux.

---
 rtl/alu_result_mux_pipe_pkg.sv | 36 +++
 rtl/alu_skid_buf.sv | 65 ++++++
 rtl/alu_result_mux_pipe.sv | 72 +++++++
 tb/tb_alu_result_mux_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_mux_pipe_pkg.sv
// Shared constants and types for the ALU result selector pipeline.
// Holds result-select indices, default sizes and the skid state encoding.
package alu_result_mux_pipe_pkg;

    localparam int ALU_WIDTH       = 64;
    localparam int ALU_NUM_RESULTS = 8;

    localparam int SEL_A = 0;
    localparam int SEL_B = 1;
    localparam int SEL_C = 2;
    localparam int SEL_D = 3;
    localparam int SEL_E = 4;
    localparam int SEL_F = 5;
    localparam int SEL_G = 6;
    localparam int SEL_H = 7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } skid_state_e;

    // State is implied by the two valid bits; skid valid dominates.
    function automatic skid_state_e skid_state(
        input logic ov,
        input logic sv
    );
        if (sv)
            return ST_SKID;
        else if (ov)
            return ST_FULL;
        else
            return ST_EMPTY;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry skid buffer: output register plus one skid slot.
// Ports: clk, rst, in_data/in_valid/in_ready, out_data/out_valid/out_ready.
module alu_skid_buf
    import alu_result_mux_pipe_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [DW-1:0] skid_q;
    logic          skid_v;
    logic          acc;
    logic          xfr;
    skid_state_e   state;

    // Ready comes straight from a flop, never from out_ready.
    assign in_ready = !skid_v;
    assign acc      = in_valid && !skid_v;
    assign xfr      = out_valid && out_ready;
    assign state    = skid_state(out_valid, skid_v);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            skid_q    <= '0;
            skid_v    <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (acc && xfr) begin
                        out_data <= in_data;
                    end else if (acc) begin
                        skid_q <= in_data;
                        skid_v <= 1'b1;
                    end else if (xfr) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (xfr) begin
                        out_data <= skid_q;
                        skid_v   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_mux_pipe.sv
// NUM_IN-to-1 ALU result selector registered behind a skid buffer.
// Ports: clk, rst, in_data/in_sel/in_valid/in_ready,
//   out_data/out_sel_err/out_valid/out_ready, out_zero (ALU_MUX_ZERO_FLAG_EN).
module alu_result_mux_pipe
    import alu_result_mux_pipe_pkg::*;
#(
    parameter  int WIDTH  = ALU_WIDTH,
    parameter  int NUM_IN = ALU_NUM_RESULTS,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
`ifdef ALU_MUX_ZERO_FLAG_EN
    output logic                    out_zero,
`endif
    output logic                    out_valid,
    input  logic                    out_ready
);

`ifdef ALU_MUX_ZERO_FLAG_EN
    localparam int FW = 2;
`else
    localparam int FW = 1;
`endif
    localparam int DW = WIDTH + FW;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [DW-1:0]    pl_in;
    logic [DW-1:0]    pl_out;

    // Out-of-range indices fall through with zero data and err set.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

`ifdef ALU_MUX_ZERO_FLAG_EN
    assign pl_in    = {(sel_data == '0), sel_err, sel_data};
    assign out_zero = pl_out[WIDTH+1];
`else
    assign pl_in    = {sel_err, sel_data};
`endif
    assign out_sel_err = pl_out[WIDTH];
    assign out_data    = pl_out[WIDTH-1:0];

    alu_skid_buf #(
        .DW(DW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (pl_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (pl_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// Directed and random checks for alu_result_mux_pipe (NUM_IN=8 and NUM_IN=5).
// Zero-flag checks build only with ALU_MUX_ZERO_FLAG_EN.
module tb_alu_result_mux_pipe;

    logic         clk = 1'b0;
    logic         rst;

    logic [511:0] in_data;
    logic [2:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  out_data;
    logic         out_sel_err;
    logic         out_valid;
    logic         out_ready;

    logic [319:0] in_data5;
    logic [2:0]   in_sel5;
    logic         in_valid5;
    logic         in_ready5;
    logic [63:0]  out_data5;
    logic         out_sel_err5;
    logic         out_valid5;
    logic         out_ready5;

`ifdef ALU_MUX_ZERO_FLAG_EN
    logic         out_zero;
    logic         out_zero5;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_mux_pipe #(.WIDTH(64), .NUM_IN(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_sel_err(out_sel_err),
`ifdef ALU_MUX_ZERO_FLAG_EN
        .out_zero   (out_zero),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    alu_result_mux_pipe #(.WIDTH(64), .NUM_IN(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data5),
        .in_sel     (in_sel5),
        .in_valid   (in_valid5),
        .in_ready   (in_ready5),
        .out_data   (out_data5),
        .out_sel_err(out_sel_err5),
`ifdef ALU_MUX_ZERO_FLAG_EN
        .out_zero   (out_zero5),
`endif
        .out_valid  (out_valid5),
        .out_ready  (out_ready5)
    );

    function automatic logic [63:0] pat(input int k);
        logic [3:0] n;
        n = (k < 6) ? 4'(10 + k) : 4'(k - 5);
        return {16{n}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] q[$];
        logic [63:0] e;
        int acc_n;
        int cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        out_ready = 1'b1;
        in_valid5 = 1'b0;
        in_sel5   = 3'd0;
        out_ready5 = 1'b1;
        for (int k = 0; k < 8; k++) in_data[k*64 +: 64] = pat(k);
        for (int k = 0; k < 5; k++) in_data5[k*64 +: 64] = pat(k);

        step;
        step;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_err", 64'(out_sel_err), 64'd0);
`ifdef ALU_MUX_ZERO_FLAG_EN
        chk("rst_zero", 64'(out_zero), 64'd0);
`endif
        rst = 1'b0;
        step;

        // sweep: one beat per cycle, result one cycle later
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = 3'(i);
            step;
            chk($sformatf("sweep_data%0d", i), out_data, pat(i));
            chk($sformatf("sweep_valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("sweep_err%0d", i), 64'(out_sel_err), 64'd0);
            chk($sformatf("sweep_ready%0d", i), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step;
        chk("sweep_drain", 64'(out_valid), 64'd0);

        // backpressure into the skid slot
        in_valid = 1'b1;
        in_sel   = 3'd2;
        step;
        chk("bp_c", out_data, pat(2));
        out_ready = 1'b0;
        in_sel    = 3'd3;
        step;
        chk("bp_ready0", 64'(in_ready), 64'd0);
        chk("bp_hold_c", out_data, pat(2));
        in_sel = 3'd5;
        step;
        chk("bp_hold_c2", out_data, pat(2));
        chk("bp_ready0b", 64'(in_ready), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        chk("bp_d", out_data, pat(3));
        chk("bp_ready1", 64'(in_ready), 64'd1);
        chk("bp_valid", 64'(out_valid), 64'd1);
        step;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // async reset with both entries occupied
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_sel    = 3'd1;
        step;
        step;
        chk("mid_skid", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        rst = 1'b0;
        step;

        // out-of-range select on the 5-input instance
        in_valid5 = 1'b1;
        in_sel5   = 3'd6;
        step;
        chk("oor_data", out_data5, 64'd0);
        chk("oor_err", 64'(out_sel_err5), 64'd1);
`ifdef ALU_MUX_ZERO_FLAG_EN
        chk("oor_zero", 64'(out_zero5), 64'd1);
`endif
        in_sel5 = 3'd4;
        step;
        chk("oor_next_data", out_data5, pat(4));
        chk("oor_next_err", 64'(out_sel_err5), 64'd0);
        in_valid5 = 1'b0;
        step;
        chk("oor_drain", 64'(out_valid5), 64'd0);

`ifdef ALU_MUX_ZERO_FLAG_EN
        in_data[3*64 +: 64] = 64'd0;
        in_valid = 1'b1;
        in_sel   = 3'd3;
        step;
        chk("zero_set", 64'(out_zero), 64'd1);
        chk("zero_data", out_data, 64'd0);
        in_sel = 3'd0;
        step;
        chk("zero_clr", 64'(out_zero), 64'd0);
        in_valid = 1'b0;
        step;
        in_data[3*64 +: 64] = pat(3);
`endif

        // random valid/ready against a scoreboard queue
        acc_n = 0;
        cyc   = 0;
        while (acc_n < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_sel    = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++)
                in_data[k*64 +: 64] = {$urandom(), $urandom()};
            if (out_valid && out_ready) begin
                chk("rnd_occ", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rnd_data", out_data, e);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(in_data[int'(in_sel)*64 +: 64]);
                acc_n++;
            end
            step;
            cyc++;
        end
        chk("rnd_budget", 64'(acc_n), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                chk("drain_occ", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("drain_data", out_data, e);
                end
            end
            step;
        end
        chk("rnd_left", 64'(q.size()), 64'd0);
        chk("rnd_idle", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
